// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the writeback port arbiter: producer records, port records
// and the wrap-aware uid age compare.
package wb_port_arbiter_pkg;

  localparam int WB_SRC_NUM   = 4;
  localparam int WB_PORTS     = 2;
  localparam int WB_BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    WB_EX0 = 2'd0,
    WB_EX1 = 2'd1,
    WB_LSU = 2'd2,
    WB_MD  = 2'd3
  } wb_src_e;

  typedef struct packed {
    logic        ready;
    logic [7:0]  uid;
    logic [4:0]  rf_dst;
    logic [31:0] rf_wdata;
  } wb_entry_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        retire;
    logic [7:0]  uid;
  } wb_port_t;

  // a is older than b when b is 1..127 ahead of a on the 8-bit uid ring.
  function automatic logic uid_older(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] d;
    d = b - a;
    return (d != 8'd0) && (d < 8'd128);
  endfunction

endpackage

// File: rtl/wb_src_fifo.sv
// Per-producer writeback FIFO; ready depends on the registered count only,
// so a full FIFO stays not-ready even in a cycle where it is popped.
module wb_src_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH = WB_BUF_DEPTH
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  input  logic      i_flush,
  input  logic      i_push,
  input  wb_entry_t i_entry,
  input  logic      i_pop,
  output logic      o_ready,
  output logic      o_head_v,
  output wb_entry_t o_head
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  wb_entry_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          push_ok;
  logic          pop_ok;

  assign o_ready  = (count_reg != FULL);
  assign o_head_v = (count_reg != '0);
  assign o_head   = mem[rd_ptr_reg];
  assign push_ok  = i_push && o_ready && !i_flush;
  assign pop_ok   = i_pop && o_head_v && !i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (i_flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + (AW + 1)'(1);
        2'b01:   count_reg <= count_reg - (AW + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage is not reset; the count alone decides which slots are live.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr_reg] <= i_entry;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Rotating-priority arbiter draining four writeback FIFOs into two registered
// regfile write ports plus scoreboard release strobes.
module wb_port_arbiter #(
  parameter int SRC_NUM   = wb_port_arbiter_pkg::WB_SRC_NUM,
  parameter int WB_PORTS  = wb_port_arbiter_pkg::WB_PORTS,
  parameter int BUF_DEPTH = wb_port_arbiter_pkg::WB_BUF_DEPTH
) (
  input  logic                                          i_clk,
  input  logic                                          i_rst_n,
  input  logic                                          i_flush,
  input  logic [SRC_NUM-1:0]                            i_src_valid,
  input  wb_port_arbiter_pkg::wb_entry_t [SRC_NUM-1:0]  i_src_entry,
  output logic [SRC_NUM-1:0]                            o_src_ready,
  output logic [WB_PORTS-1:0]                           o_rf_we,
  output logic [WB_PORTS-1:0][4:0]                      o_rf_waddr,
  output logic [WB_PORTS-1:0][31:0]                     o_rf_wdata,
  output logic [WB_PORTS-1:0]                           o_retire_v,
  output logic [WB_PORTS-1:0][7:0]                      o_retire_uid,
  output logic [31:0]                                   o_stall_cnt
);
  import wb_port_arbiter_pkg::*;

  localparam int PTR_W = (SRC_NUM > 1) ? $clog2(SRC_NUM) : 1;

  logic [PTR_W-1:0]    ptr_reg;
  logic [PTR_W-1:0]    ptr_next;
  logic [SRC_NUM-1:0]  head_v;
  logic [SRC_NUM-1:0]  gnt;
  logic [SRC_NUM-1:0]  head_ready_unused;
  wb_entry_t           head [SRC_NUM];
  logic                c0_v;
  logic                c1_v;
  logic [PTR_W-1:0]    c0_idx;
  logic [PTR_W-1:0]    c1_idx;
  logic                conflict;
  logic [WB_PORTS-1:0] g_v;
  logic [PTR_W-1:0]    g_idx [WB_PORTS];
  logic                stall;
  wb_port_t            port_reg  [WB_PORTS];
  wb_port_t            port_next [WB_PORTS];
  logic [31:0]         stall_cnt_reg;

  function automatic logic [PTR_W-1:0] scan_idx(input logic [PTR_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= SRC_NUM) s -= SRC_NUM;
    return PTR_W'(s);
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < SRC_NUM; gi++) begin : g_src
      wb_src_fifo #(
        .DEPTH (BUF_DEPTH)
      ) u_fifo (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_flush  (i_flush),
        .i_push   (i_src_valid[gi]),
        .i_entry  (i_src_entry[gi]),
        .i_pop    (gnt[gi]),
        .o_ready  (o_src_ready[gi]),
        .o_head_v (head_v[gi]),
        .o_head   (head[gi])
      );
      // The producer-side ready field carries no meaning past the FIFO.
      assign head_ready_unused[gi] = head[gi].ready;
    end
  endgenerate

  // First two non-empty heads in rotating scan order.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx    = '0;
    c0_v   = 1'b0;
    c1_v   = 1'b0;
    c0_idx = '0;
    c1_idx = '0;
    for (int k = 0; k < SRC_NUM; k++) begin
      idx = scan_idx(ptr_reg, k);
      if (head_v[idx]) begin
        if (!c0_v) begin
          c0_v   = 1'b1;
          c0_idx = idx;
        end else if (!c1_v) begin
          c1_v   = 1'b1;
          c1_idx = idx;
        end
      end
    end
  end

  assign conflict = c0_v && c1_v && (head[c0_idx].rf_dst != 5'd0) &&
                    (head[c0_idx].rf_dst == head[c1_idx].rf_dst);

  always_comb begin
    g_v      = '0;
    g_idx[0] = c0_idx;
    g_idx[1] = c1_idx;
    if (!i_flush && c0_v) begin
      g_v[0] = 1'b1;
      // On a destination clash only the older record goes, always on port 0.
      if (conflict) begin
        if (uid_older(head[c1_idx].uid, head[c0_idx].uid)) g_idx[0] = c1_idx;
      end else begin
        g_v[1] = c1_v;
      end
    end

    gnt = '0;
    for (int p = 0; p < WB_PORTS; p++) begin
      if (g_v[p]) gnt[g_idx[p]] = 1'b1;
    end

    ptr_next = ptr_reg;
    if (g_v[1])      ptr_next = scan_idx(g_idx[1], 1);
    else if (g_v[0]) ptr_next = scan_idx(g_idx[0], 1);

    for (int p = 0; p < WB_PORTS; p++) begin
      port_next[p] = '0;
      if (g_v[p]) begin
        port_next[p].we     = (head[g_idx[p]].rf_dst != 5'd0);
        port_next[p].waddr  = head[g_idx[p]].rf_dst;
        port_next[p].wdata  = head[g_idx[p]].rf_wdata;
        port_next[p].retire = 1'b1;
        port_next[p].uid    = head[g_idx[p]].uid;
      end
    end

    stall = !i_flush && ((head_v & ~gnt) != '0);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_reg       <= '0;
      stall_cnt_reg <= '0;
      for (int p = 0; p < WB_PORTS; p++) port_reg[p] <= '0;
    end else begin
      ptr_reg <= ptr_next;
      for (int p = 0; p < WB_PORTS; p++) port_reg[p] <= port_next[p];
      if (stall && (stall_cnt_reg != '1)) stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  generate
    for (gi = 0; gi < WB_PORTS; gi++) begin : g_out
      assign o_rf_we[gi]      = port_reg[gi].we;
      assign o_rf_waddr[gi]   = port_reg[gi].waddr;
      assign o_rf_wdata[gi]   = port_reg[gi].wdata;
      assign o_retire_v[gi]   = port_reg[gi].retire;
      assign o_retire_uid[gi] = port_reg[gi].uid;
    end
  endgenerate

  assign o_stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: stimulus queues expected writebacks,
// a negedge monitor pops and compares whenever a port retires.
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  localparam int SRC_NUM = 4;

  typedef struct {
    int          port;
    int          cyc;
    bit          we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [7:0]  uid;
  } exp_t;

  logic                          clk;
  logic                          rst_n;
  logic                          flush;
  logic [SRC_NUM-1:0]            src_valid;
  wb_entry_t [SRC_NUM-1:0]       src_entry;
  logic [SRC_NUM-1:0]            src_ready;
  logic [WB_PORTS-1:0]           rf_we;
  logic [WB_PORTS-1:0][4:0]      rf_waddr;
  logic [WB_PORTS-1:0][31:0]     rf_wdata;
  logic [WB_PORTS-1:0]           retire_v;
  logic [WB_PORTS-1:0][7:0]      retire_uid;
  logic [31:0]                   stall_cnt;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   k;

  wb_port_arbiter dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_flush      (flush),
    .i_src_valid  (src_valid),
    .i_src_entry  (src_entry),
    .o_src_ready  (src_ready),
    .o_rf_we      (rf_we),
    .o_rf_waddr   (rf_waddr),
    .o_rf_wdata   (rf_wdata),
    .o_retire_v   (retire_v),
    .o_retire_uid (retire_uid),
    .o_stall_cnt  (stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, got, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int s, input logic [7:0] u, input logic [4:0] rd, input logic [31:0] d);
    src_valid[s] = 1'b1;
    src_entry[s] = '{ready: 1'b0, uid: u, rf_dst: rd, rf_wdata: d};
  endtask

  task automatic expect_wb(input int port, input int c, input logic [7:0] u,
                           input logic [4:0] rd, input logic [31:0] d);
    exp_t e;
    e.port  = port;
    e.cyc   = c;
    e.we    = (rd != 5'd0);
    e.waddr = rd;
    e.wdata = d;
    e.uid   = u;
    exp_q.push_back(e);
    $display("push  port%0d cycle %0d uid %0d rd %0d data 0x%08h", port, c, u, rd, d);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_we"},    64'(rf_we),      64'd0);
    check_eq({tag, "_rv"},    64'(retire_v),   64'd0);
    check_eq({tag, "_waddr"}, 64'(rf_waddr),   64'd0);
    check_eq({tag, "_wdata"}, 64'(rf_wdata),   64'd0);
    check_eq({tag, "_uid"},   64'(retire_uid), 64'd0);
    check_eq({tag, "_ready"}, 64'(src_ready),  64'hF);
    check_eq({tag, "_stall"}, 64'(stall_cnt),  64'd0);
  endtask

  // Monitor: one compared record per retiring port.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (retire_v != '0) check_eq("port_order", 64'(retire_v == 2'b10), 64'd0);
      for (int p = 0; p < WB_PORTS; p++) begin
        if (rf_we[p]) check_eq("we_without_retire", 64'(retire_v[p]), 64'd1);
        if (retire_v[p]) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_wb: port%0d uid %0d rd %0d at cycle %0d, required no write",
                     p, retire_uid[p], rf_waddr[p], cyc);
          end else begin
            e = exp_q.pop_front();
            $display("wb    port%0d cycle %0d uid %0d we %0d rd %0d data 0x%08h",
                     p, cyc, retire_uid[p], rf_we[p], rf_waddr[p], rf_wdata[p]);
            check_eq("wb_port",  64'(p),             64'(e.port));
            check_eq("wb_cycle", 64'(cyc),           64'(e.cyc));
            check_eq("wb_uid",   64'(retire_uid[p]), 64'(e.uid));
            check_eq("wb_we",    64'(rf_we[p]),      64'(e.we));
            check_eq("wb_waddr", 64'(rf_waddr[p]),   64'(e.waddr));
            if (e.we) check_eq("wb_wdata", 64'(rf_wdata[p]), 64'(e.wdata));
          end
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    src_valid = '0;
    src_entry = '0;
    #7;
    check_idle("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Single ex0 record: two-cycle latency, one-cycle pulse. ptr -> 1.
    k = cyc;
    set_src(WB_EX0, 8'd5, 5'd3, 32'hDEAD_BEEF);
    expect_wb(0, k + 2, 8'd5, 5'd3, 32'hDEAD_BEEF);
    tick();
    src_valid = '0;
    repeat (3) tick();

    // x0 destination from md: retire without write. ptr -> 0.
    k = cyc;
    set_src(WB_MD, 8'd9, 5'd0, 32'h0000_1234);
    expect_wb(0, k + 2, 8'd9, 5'd0, 32'h0000_1234);
    tick();
    src_valid = '0;
    repeat (3) tick();

    // All four sources: ex0/ex1 first, lsu/md next; one stall cycle.
    k = cyc;
    set_src(WB_EX0, 8'd10, 5'd1, 32'hA000_0000);
    set_src(WB_EX1, 8'd11, 5'd2, 32'hA000_0001);
    set_src(WB_LSU, 8'd12, 5'd3, 32'hA000_0002);
    set_src(WB_MD,  8'd13, 5'd4, 32'hA000_0003);
    expect_wb(0, k + 2, 8'd10, 5'd1, 32'hA000_0000);
    expect_wb(1, k + 2, 8'd11, 5'd2, 32'hA000_0001);
    expect_wb(0, k + 3, 8'd12, 5'd3, 32'hA000_0002);
    expect_wb(1, k + 3, 8'd13, 5'd4, 32'hA000_0003);
    tick();
    src_valid = '0;
    repeat (4) tick();
    check_eq("stall_after_quad", 64'(stall_cnt), 64'd1);

    // Same rd, uid 250 older than uid 2 across the wrap. ptr 0 -> 1 -> 3.
    k = cyc;
    set_src(WB_EX0, 8'd250, 5'd7, 32'hB000_0000);
    set_src(WB_LSU, 8'd2,   5'd7, 32'hB000_0002);
    expect_wb(0, k + 2, 8'd250, 5'd7, 32'hB000_0000);
    expect_wb(0, k + 3, 8'd2,   5'd7, 32'hB000_0002);
    tick();
    src_valid = '0;
    repeat (4) tick();

    // Same rd, later-scanned ex1 is older: it takes port 0. ptr 3 -> 2 -> 1.
    k = cyc;
    set_src(WB_EX0, 8'd100, 5'd8, 32'hC000_0000);
    set_src(WB_EX1, 8'd90,  5'd8, 32'hC000_0001);
    expect_wb(0, k + 2, 8'd90,  5'd8, 32'hC000_0001);
    expect_wb(0, k + 3, 8'd100, 5'd8, 32'hC000_0000);
    tick();
    src_valid = '0;
    repeat (4) tick();
    check_eq("stall_after_conflicts", 64'(stall_cnt), 64'd3);

    // Move ptr to 2 with a single ex1 record.
    k = cyc;
    set_src(WB_EX1, 8'd20, 5'd5, 32'hD000_0000);
    expect_wb(0, k + 2, 8'd20, 5'd5, 32'hD000_0000);
    tick();
    src_valid = '0;
    repeat (3) tick();

    // lsu/md win the slots while ex1 fills to two entries, then flush.
    k = cyc;
    set_src(WB_LSU, 8'd30, 5'd11, 32'hE000_0000);
    set_src(WB_MD,  8'd31, 5'd12, 32'hE000_0001);
    set_src(WB_EX1, 8'd32, 5'd13, 32'hE000_0002);
    expect_wb(0, k + 2, 8'd30, 5'd11, 32'hE000_0000);
    expect_wb(1, k + 2, 8'd31, 5'd12, 32'hE000_0001);
    tick();
    src_valid = '0;
    set_src(WB_EX1, 8'd33, 5'd14, 32'hE000_0003);
    tick();
    src_valid = '0;
    check_eq("ex1_full_ready", 64'(src_ready), 64'hD);
    flush = 1'b1;
    set_src(WB_EX0, 8'd40, 5'd15, 32'hF000_0000);
    tick();
    flush     = 1'b0;
    src_valid = '0;
    check_eq("ready_after_flush", 64'(src_ready), 64'hF);
    repeat (4) tick();
    check_eq("stall_after_flush", 64'(stall_cnt), 64'd4);

    // Async reset while lsu/md are still waiting: they must never appear.
    k = cyc;
    set_src(WB_EX0, 8'd60, 5'd21, 32'h6000_0000);
    set_src(WB_EX1, 8'd61, 5'd22, 32'h6000_0001);
    set_src(WB_LSU, 8'd62, 5'd23, 32'h6000_0002);
    set_src(WB_MD,  8'd63, 5'd24, 32'h6000_0003);
    expect_wb(0, k + 2, 8'd60, 5'd21, 32'h6000_0000);
    expect_wb(1, k + 2, 8'd61, 5'd22, 32'h6000_0001);
    tick();
    src_valid = '0;
    tick();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_idle("async_reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) tick();
    check_eq("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
